pdp8_mem_arbiter: RTL
=====================

// Module: pdp8_mem_arbiter
//
// PURPOSE
//  Shares the single pdp8_ram port between two requesters: the CPU and the
//  I/O DMA path (disk/console block transfers). It sits between those
//  requesters and pdp8_ram, so the CPU no longer multiplexes external RAM
//  requests itself. It runs one access at a time, in three phases:
//  grant -> RAM strobe for RAM_LAT cycles -> done pulse.
//  Arbitration is DMA-first, with a bounded starvation guard for the CPU.
//
// PARAMETERS
//  ADDR_W      15  word address width (8 fields x 4K)
//  DATA_W      12  word width
//  RAM_LAT      2  cycles ram_rd/ram_wr held per access (>=1)
//  CPU_STARVE   3  max consecutive DMA grants while CPU waits (>=1)
//
// PORTS
//  clk         in   1       system clock; all logic on rising edge
//  reset       in   1       asynchronous, active-high
//  cpu_req     in   1       CPU access request; level, held until cpu_done
//  cpu_we      in   1       1=write, 0=read; stable while cpu_req
//  cpu_addr    in   ADDR_W  CPU address; stable while cpu_req
//  cpu_wdata   in   DATA_W  CPU write data; stable while cpu_req
//  cpu_done    out  1       one-cycle completion pulse
//  cpu_rdata   out  DATA_W  read data; valid with cpu_done, held after
//  dma_req     in   1       DMA access request (same protocol as CPU)
//  dma_we      in   1       1=write, 0=read
//  dma_addr    in   ADDR_W  DMA address
//  dma_wdata   in   DATA_W  DMA write data
//  dma_done    out  1       one-cycle completion pulse
//  dma_rdata   out  DATA_W  read data; valid with dma_done, held after
//  ram_addr    out  ADDR_W  to pdp8_ram addr
//  ram_wdata   out  DATA_W  to pdp8_ram data_in
//  ram_rdata   in   DATA_W  from pdp8_ram data_out
//  ram_rd      out  1       RAM read strobe
//  ram_wr      out  1       RAM write strobe
//  busy        out  1       state != IDLE
//  owner_dma   out  1       1 = current or last grant went to DMA
//
// BEHAVIOUR
//  - Reset: state=IDLE. Every output is 0: strobes, done pulses, rdata,
//    ram_addr/ram_wdata, busy, owner_dma, starve counter.
//  - States: IDLE -> ACCESS -> RESP -> IDLE. Everything is registered;
//    there are no combinational paths from requester inputs to outputs.
//  - IDLE: sample cpu_req and dma_req.
//      - Only one requester asserted: it wins.
//      - Both asserted: DMA wins unless starve == CPU_STARVE; then CPU wins.
//      - On a grant, latch addr, we and wdata into ram_addr/ram_wdata,
//        set owner_dma, load beat counter = RAM_LAT, go to ACCESS.
//  - ACCESS: ram_rd = ~we, ram_wr = we for exactly RAM_LAT cycles.
//      - ram_addr/ram_wdata are stable for the whole window.
//      - ram_rdata is captured into the owner's rdata on the last ACCESS
//        cycle. The other requester's rdata is untouched.
//  - RESP: owner's done = 1 for exactly one cycle; strobes = 0; -> IDLE.
//  - Latency: request seen in IDLE at cycle 0 -> strobes in cycles
//    1..RAM_LAT -> done in cycle RAM_LAT+1 -> IDLE in cycle RAM_LAT+2.
//    Back-to-back throughput is one access per RAM_LAT+2 cycles.
//  - Request protocol:
//      - A requester must drop req in the cycle after done.
//      - A req seen high in IDLE is a new request.
//      - req, we, addr and wdata changes during ACCESS/RESP are ignored.
//  - Starvation counter:
//      - Increments (saturating at CPU_STARVE) on a DMA grant made while
//        cpu_req is high.
//      - Clears on any CPU grant.
//      - Clears on a DMA grant made while cpu_req is low.
//  - Widths: address and data pass through unmodified; no field or address
//    wrap is performed here.
//  - Asynchronous reset mid-access: strobes drop immediately and state goes
//    to IDLE. No done is issued for the aborted access; a RAM write may be
//    partial.
//
// TESTING
//  - Single CPU read, RAM_LAT=2, addr 15'o07400 preloaded 12'o7402 ->
//    ram_rd high cycles 1-2, cpu_done in cycle 3, cpu_rdata=12'o7402,
//    dma_done stays 0.
//  - CPU and DMA both request in the same IDLE cycle -> DMA served first;
//    CPU granted in the IDLE after dma_done; both done pulses one cycle wide.
//  - DMA holds req continuously (re-asserts each IDLE), CPU waiting,
//    CPU_STARVE=3 -> grant order DMA, DMA, DMA, CPU, DMA...
//  - DMA write 12'o1234 to 15'o17777, then CPU read of the same address ->
//    cpu_rdata=12'o1234; ram_wr is high exactly RAM_LAT cycles with
//    ram_addr stable.
//  - Assert reset during the second ACCESS cycle of a write ->
//    ram_wr low and busy low asynchronously; no done pulse; all outputs 0.
//  - Requester changes cpu_addr in mid-ACCESS -> ram_addr keeps the
//    latched value; the next request after done uses the new address.

Source files
------------

// File: rtl/pdp8_mem_arbiter.sv
// Shares one pdp8_ram port between the CPU and the DMA path, one access at a time.
// Sequence: grant (IDLE) -> RAM_LAT strobe cycles (ACCESS) -> one-cycle done (RESP).
module pdp8_mem_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 12,
    parameter int RAM_LAT    = 2,
    parameter int CPU_STARVE = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_done,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic              busy,
    output logic              owner_dma
);
    localparam int BEAT_W = $clog2(RAM_LAT + 1);
    localparam int STV_W  = $clog2(CPU_STARVE + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BEAT_W-1:0] r_beat;
    logic [STV_W-1:0]  r_starve;
    logic              r_we;
    logic              r_owner_dma;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;
    logic              w_grant_dma;
    logic              w_grant_cpu;
    logic              w_last_beat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_dma = 1'b0;
        w_grant_cpu = 1'b0;
        w_last_beat = (r_beat == BEAT_W'(1));
        case (r_state)
            S_IDLE: begin
                // DMA has priority until the CPU has been passed over CPU_STARVE times.
                w_grant_dma = dma_req && (!cpu_req || (r_starve != STV_W'(CPU_STARVE)));
                w_grant_cpu = cpu_req && !w_grant_dma;
                if (w_grant_dma || w_grant_cpu) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_last_beat) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat      <= '0;
            r_starve    <= '0;
            r_we        <= 1'b0;
            r_owner_dma <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            if (w_grant_dma || w_grant_cpu) begin
                r_owner_dma <= w_grant_dma;
                r_we        <= w_grant_dma ? dma_we    : cpu_we;
                r_ram_addr  <= w_grant_dma ? dma_addr  : cpu_addr;
                r_ram_wdata <= w_grant_dma ? dma_wdata : cpu_wdata;
                r_beat      <= BEAT_W'(RAM_LAT);
            end
            if (w_grant_cpu || (w_grant_dma && !cpu_req)) begin
                r_starve <= '0;
            end else if (w_grant_dma && (r_starve != STV_W'(CPU_STARVE))) begin
                r_starve <= r_starve + STV_W'(1);
            end
            if (r_state == S_ACCESS) begin
                r_beat <= r_beat - BEAT_W'(1);
                if (w_last_beat) begin
                    if (r_owner_dma) begin
                        r_dma_rdata <= ram_rdata;
                    end else begin
                        r_cpu_rdata <= ram_rdata;
                    end
                end
            end
        end
    end

    // Strobes and done are pure decodes of registered state, so reset kills them at once.
    assign ram_rd    = (r_state == S_ACCESS) && !r_we;
    assign ram_wr    = (r_state == S_ACCESS) &&  r_we;
    assign cpu_done  = (r_state == S_RESP) && !r_owner_dma;
    assign dma_done  = (r_state == S_RESP) &&  r_owner_dma;
    assign busy      = (r_state != S_IDLE);
    assign owner_dma = r_owner_dma;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
endmodule
